// File: rtl/mem_writeback.sv
// mem_writeback -- memory-access / register-writeback stage.
//
// Accepts one operation at a time from the upstream stage (in_valid/in_ready
// handshake, in_ready high only in IDLE). Register-only operations with
// writereg=1 write aluresult back the next cycle. Loads and stores issue a
// single held data-memory request (mem_req..mem_wdata registered and stable
// until mem_ack is sampled). Loads with writereg=1 write mem_rdata back the
// cycle after the ack. writeflag is high for exactly the one WB cycle.
//
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after 16
// un-acked cycles and pulse mem_err for one cycle. Without it mem_err is 0
// and ACCESS waits indefinitely.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready     operation handshake
//   aluresult, writereg,    operation fields, latched on acceptance
//   memwrite, regaddress,   (memwrite: 00 none, 01 load, 10 store, 11 none)
//   address, storedata
//   mem_req, mem_we,        data-memory request (held until mem_ack)
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata      memory completion and read data
//   writeflag, writetarget, register-file write port
//   writeval
//   mem_err                 one-cycle timeout pulse
module mem_writeback (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] aluresult,
  input  logic        writereg,
  input  logic [1:0]  memwrite,
  input  logic [2:0]  regaddress,
  input  logic [15:0] address,
  input  logic [15:0] storedata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        writeflag,
  output logic [3:0]  writetarget,
  output logic [15:0] writeval,
  output logic        mem_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WB     = 2'd2;

  logic [1:0]  r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [3:0]  r_writetarget;
  logic [15:0] r_writeval;
  logic        r_is_load;
  logic        r_writereg;
`ifdef MEM_TIMEOUT_EN
  logic [3:0]  r_tcnt;
  logic        r_mem_err;
`endif

  logic w_accept;
  logic w_is_mem;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_is_mem = (memwrite == 2'b01) || (memwrite == 2'b10);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_writetarget <= '0;
      r_writeval    <= '0;
      r_is_load     <= 1'b0;
      r_writereg    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_tcnt        <= '0;
      r_mem_err     <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      r_mem_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_writetarget <= {1'b0, regaddress};
            r_writereg    <= writereg;
            r_is_load     <= (memwrite == 2'b01);
            if (w_is_mem) begin
              r_state     <= S_ACCESS;
              r_mem_req   <= 1'b1;
              r_mem_we    <= (memwrite == 2'b10);
              r_mem_addr  <= address;
              r_mem_wdata <= storedata;
`ifdef MEM_TIMEOUT_EN
              r_tcnt      <= '0;
`endif
            end else if (writereg) begin
              r_state    <= S_WB;
              r_writeval <= aluresult;
            end
          end
        end
        S_ACCESS: begin
          // An ack sampled in the final counted cycle takes priority over
          // the timeout, so this test must come first.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_is_load) begin
              r_writeval <= mem_rdata;
              r_state    <= r_writereg ? S_WB : S_IDLE;
            end else begin
              r_state <= S_IDLE;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_tcnt == 4'hF) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 4'd1;
          end
`endif
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign writeflag   = (r_state == S_WB);
  assign writetarget = r_writetarget;
  assign writeval    = r_writeval;
`ifdef MEM_TIMEOUT_EN
  assign mem_err     = r_mem_err;
`else
  assign mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// Testbench for mem_writeback: directed scenarios plus randomized operations
// checked against a transaction-level model (expected writebacks derived from
// each operation's fields, and a shadow register file).
module tb_mem_writeback;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] aluresult;
  logic        writereg;
  logic [1:0]  memwrite;
  logic [2:0]  regaddress;
  logic [15:0] address;
  logic [15:0] storedata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        writeflag;
  logic [3:0]  writetarget;
  logic [15:0] writeval;
  logic        mem_err;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned n_exp_wb;
  int unsigned n_wb_seen;

  logic [15:0] model_rf [8];
  logic [15:0] dut_rf   [8];

  logic [1:0]  t_mw;
  logic        t_wr;
  logic [2:0]  t_ra;
  logic [15:0] t_alu;
  logic [15:0] t_addr;
  logic [15:0] t_sd;
  logic [15:0] t_rd;
  int unsigned t_k;
  logic        t_stray;

  mem_writeback dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluresult  (aluresult),
    .writereg   (writereg),
    .memwrite   (memwrite),
    .regaddress (regaddress),
    .address    (address),
    .storedata  (storedata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .writeflag  (writeflag),
    .writetarget(writetarget),
    .writeval   (writeval),
    .mem_err    (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shadow of the external register file, built only from observed strobes.
  always @(posedge clock) begin
    if (writeflag === 1'b1) begin
      dut_rf[writetarget[2:0]] <= writeval;
      n_wb_seen <= n_wb_seen + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation starting at a falling edge while the DUT is idle.
  // k = cycle (1-based) of mem_req in which mem_ack is driven.
  task automatic do_op(input logic [1:0] mw, input logic wr, input logic [2:0] ra,
                       input logic [15:0] alu, input logic [15:0] addr,
                       input logic [15:0] sd, input int unsigned k,
                       input logic [15:0] rd, input logic stray);
    logic        is_mem;
    logic        is_load;
    logic        exp_wb;
    logic [15:0] exp_val;
    is_mem  = (mw == 2'b01) || (mw == 2'b10);
    is_load = (mw == 2'b01);
    exp_wb  = is_mem ? (is_load && wr) : wr;
    exp_val = is_load ? rd : alu;

    chk("idle_ready", in_ready, 1);
    in_valid   = 1'b1;
    memwrite   = mw;
    writereg   = wr;
    regaddress = ra;
    aluresult  = alu;
    address    = addr;
    storedata  = sd;
    mem_ack    = stray;
    mem_rdata  = 16'hDEAD;
    @(negedge clock);
    in_valid   = 1'b0;
    memwrite   = 2'($urandom);
    writereg   = 1'($urandom);
    regaddress = 3'($urandom);
    aluresult  = 16'($urandom);
    address    = 16'($urandom);
    storedata  = 16'($urandom);
    mem_ack    = 1'b0;
    if (is_mem) begin
      for (int unsigned i = 1; i <= k; i++) begin
        chk("acc_req", mem_req, 1);
        chk("acc_we", mem_we, (mw == 2'b10));
        chk("acc_addr", mem_addr, addr);
        chk("acc_wdata", mem_wdata, sd);
        chk("acc_wflag", writeflag, 0);
        chk("acc_ready", in_ready, 0);
        chk("acc_err", mem_err, 0);
        mem_ack   = (i == k);
        mem_rdata = (i == k) ? rd : 16'($urandom);
        @(negedge clock);
      end
      mem_ack = 1'b0;
      chk("post_ack_req", mem_req, 0);
    end
    if (exp_wb) begin
      chk("wb_flag", writeflag, 1);
      chk("wb_target", writetarget, {1'b0, ra});
      chk("wb_val", writeval, exp_val);
      chk("wb_ready", in_ready, 0);
      model_rf[ra] = exp_val;
      n_exp_wb++;
      mem_ack   = stray;
      mem_rdata = 16'($urandom);
      @(negedge clock);
      mem_ack = 1'b0;
    end
    chk("end_wflag", writeflag, 0);
    chk("end_ready", in_ready, 1);
    chk("end_req", mem_req, 0);
    chk("end_err", mem_err, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_exp_wb = 0; n_wb_seen = 0;
    for (int i = 0; i < 8; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    reset = 1'b0; in_valid = 1'b0; aluresult = '0; writereg = 1'b0;
    memwrite = '0; regaddress = '0; address = '0; storedata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wflag", writeflag, 0);
    chk("rst_target", writetarget, 0);
    chk("rst_val", writeval, 0);
    chk("rst_err", mem_err, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Register-only write
    do_op(2'b00, 1'b1, 3'd5, 16'h1234, 16'h0, 16'h0, 1, 16'h0, 1'b0);
    // Load, ack in third request cycle
    do_op(2'b01, 1'b1, 3'd3, 16'h5555, 16'h0040, 16'h7777, 3, 16'hBEEF, 1'b0);
    // Store, same-cycle ack
    do_op(2'b10, 1'b1, 3'd6, 16'h4444, 16'h0010, 16'h00FF, 1, 16'h1111, 1'b0);
    // Reserved encoding behaves as register-only; writereg=0 is a no-op
    do_op(2'b11, 1'b1, 3'd7, 16'hA5A5, 16'h0, 16'h0, 1, 16'h0, 1'b0);
    do_op(2'b00, 1'b0, 3'd1, 16'h9999, 16'h0, 16'h0, 1, 16'h0, 1'b0);
    // Load with writereg=0 produces no writeback
    do_op(2'b01, 1'b0, 3'd2, 16'h0, 16'h0123, 16'h0, 2, 16'hCAFE, 1'b0);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("stray_wflag", writeflag, 0);
    chk("stray_ready", in_ready, 1);
    chk("stray_req", mem_req, 0);
    @(negedge clock);
    chk("stray_wflag2", writeflag, 0);

    // Reset in the middle of a load's access
    in_valid = 1'b1; memwrite = 2'b01; writereg = 1'b1; regaddress = 3'd4;
    address = 16'h0200; storedata = 16'h0;
    @(negedge clock);
    in_valid = 1'b0;
    chk("rstacc_req_before", mem_req, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rstacc_req_async", mem_req, 0);
    chk("rstacc_ready", in_ready, 1);
    chk("rstacc_wflag", writeflag, 0);
    @(negedge clock);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("late_ack_wflag", writeflag, 0);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_ready", in_ready, 1);
    @(negedge clock);
    chk("late_ack_wflag2", writeflag, 0);

    // Ack in the 16th request cycle completes the load
    do_op(2'b01, 1'b1, 3'd0, 16'h0, 16'h0300, 16'h0, 16, 16'h600D, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // Load never acked: 16 request cycles, then a one-cycle error pulse
    in_valid = 1'b1; memwrite = 2'b01; writereg = 1'b1; regaddress = 3'd1;
    address = 16'h0400;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_req", mem_req, 1);
      chk("to_err_low", mem_err, 0);
      @(negedge clock);
    end
    chk("to_req_drop", mem_req, 0);
    chk("to_err_pulse", mem_err, 1);
    chk("to_ready", in_ready, 1);
    chk("to_wflag", writeflag, 0);
    @(negedge clock);
    chk("to_err_end", mem_err, 0);
    chk("to_wflag2", writeflag, 0);
`endif

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      t_mw    = 2'($urandom_range(0, 3));
      t_wr    = 1'($urandom);
      t_ra    = 3'($urandom);
      t_alu   = 16'($urandom);
      t_addr  = 16'($urandom);
      t_sd    = 16'($urandom);
      t_rd    = 16'($urandom);
      t_k     = $urandom_range(1, 5);
      t_stray = 1'($urandom);
      do_op(t_mw, t_wr, t_ra, t_alu, t_addr, t_sd, t_k, t_rd, t_stray);
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end

    @(negedge clock);
    chk("wb_count", n_wb_seen, n_exp_wb);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rf%0d", i), dut_rf[i], model_rf[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
